// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory responder.
package instr_mem_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        IMEM_INIT,
        IMEM_RUN
    } imem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
    } imem_ld_t;

    // Addresses below base wrap high in the 32-bit subtraction and so fault as out of range.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [31:0] diff;
        diff = addr - base;
        return (addr[1:0] != 2'b00) || ({1'b0, diff} >= ({1'b0, depth} << 2));
    endfunction

endpackage

// File: rtl/instr_mem_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, read-first.
module sdp_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Nonblocking read of the array gives the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory: NOP fill after reset, 1-cycle fetch port, valid/ready loader port.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = instr_mem_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr_in,
    output logic [31:0] instr_dat_out,
    output logic        instr_err_out,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_dat,
    output logic        ld_err_out,
    output logic        init_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_e   state, state_d;
    logic [AW-1:0] cnt, cnt_d;
    imem_ld_t      ld_req;

    logic          fetch_bad, ld_bad, ld_fire;
    logic [AW-1:0] fetch_idx, ld_idx;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic          rd_nop, rd_err, ld_err_q, ready_q, done_q;

    assign ld_req = '{addr: ld_addr, dat: ld_dat};

    assign fetch_bad = addr_fault(instr_addr_in, BASE_ADDR, DEPTH);
    assign ld_bad    = addr_fault(ld_req.addr, BASE_ADDR, DEPTH);
    assign ld_fire   = ld_valid & ready_q;

    // BASE_ADDR is DEPTH*4-aligned, so the word index is just the low address bits.
    assign fetch_idx = instr_addr_in[AW+1:2];
    assign ld_idx    = ld_req.addr[AW+1:2];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ram_we    = 1'b0;
        ram_waddr = cnt;
        ram_wdata = NOP_WORD;
        case (state)
            IMEM_INIT: begin
                ram_we = 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_d = IMEM_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            IMEM_RUN: begin
                ram_waddr = ld_idx;
                ram_wdata = ld_req.dat;
                ram_we    = ld_fire & ~ld_bad;
            end
            default: state_d = IMEM_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IMEM_INIT;
            cnt      <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            ld_err_q <= 1'b0;
            rd_nop   <= 1'b1;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            done_q   <= (state_d == IMEM_RUN);
            ready_q  <= (state_d == IMEM_RUN);
            ld_err_q <= ld_fire & ld_bad;
            rd_nop   <= (state == IMEM_INIT) | fetch_bad;
            rd_err   <= (state == IMEM_RUN) & fetch_bad;
        end
    end

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so a reset-held select flop forces NOP instead.
    assign instr_dat_out = rd_nop ? NOP_WORD : ram_rdata;
    assign instr_err_out = rd_err;
    assign ld_ready      = ready_q;
    assign ld_err_out    = ld_err_q;
    assign init_done     = done_q;

endmodule
